// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ram_arb_pkg
// Brief    : Shared state encoding and default widths for the RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin selector; search starts just after
//            last_grant and wraps, returning a one-hot winner and its index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_req
);

    assign any_req = |req;

    always_comb begin
        int   cand;
        logic found;
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = 0;
        // Offsets 1..NUM_REQ visit every requester once, last_grant itself last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                      = 1'b1;
                winner[cand[IDX_W-1:0]]    = 1'b1;
                winner_idx                 = cand[IDX_W-1:0];
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_rr_arbiter
// Brief    : Round-robin sharing of one single-port RAM between NUM_REQ
//            requesters, one access per three cycles (IDLE -> CMD -> RESP).
// Revision : 1.0 - initial release
// ============================================================================
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      ram_cs,
    output logic                      ram_read,
    output logic                      ram_write,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_wdata,
    input  logic [DATA_W-1:0]         ram_rdata
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t               r_state;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [IDX_W-1:0]     r_last;
    logic [NUM_REQ-1:0]   r_win;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   r_done;
    logic [DATA_W-1:0]    r_rdata;

    logic [NUM_REQ-1:0]   w_win;
    logic [IDX_W-1:0]     w_win_idx;
    logic                 w_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_grant (r_last),
        .winner     (w_win),
        .winner_idx (w_win_idx),
        .any_req    (w_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_win   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_we    <= req_we[w_win_idx];
                        r_addr  <= req_addr[w_win_idx*ADDR_W +: ADDR_W];
                        r_wdata <= req_wdata[w_win_idx*DATA_W +: DATA_W];
                        r_last  <= w_win_idx;
                        r_win   <= w_win;
                        r_gnt   <= w_win;
                        r_state <= CMD;
                    end
                end
                CMD: begin
                    r_state <= RESP;
                end
                RESP: begin
                    // RAM read data is valid during RESP; writes leave rdata alone.
                    if (!r_we) begin
                        r_rdata <= ram_rdata;
                    end
                    r_done  <= r_win;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // RAM strobes come only from registers, so rst removes them immediately.
    assign ram_cs    = (r_state == CMD);
    assign ram_write = ram_cs &  r_we;
    assign ram_read  = ram_cs & ~r_we;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;

    assign busy  = (r_state != IDLE);
    assign gnt   = r_gnt;
    assign done  = r_done;
    assign rdata = r_rdata;

endmodule : ram_rr_arbiter
`default_nettype wire

// File: tb/tb_ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_rr_arbiter
// Brief    : Self-checking bench for ram_rr_arbiter with a behavioural RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_rr_arbiter;

    localparam int N  = 2;
    localparam int AW = 7;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            ram_cs;
    logic            ram_read;
    logic            ram_write;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata = '0;

    logic [7:0] tb_mem [0:127] = '{default: 8'h00};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .busy      (busy),
        .ram_cs    (ram_cs),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Single-port RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (ram_cs && ram_write) tb_mem[ram_addr] <= ram_wdata;
        if (ram_cs && ram_read)  ram_rdata <= tb_mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic on, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]                = on;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // Single access by one requester; called just after a falling edge.
    task automatic do_access(input int i, input logic we, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
        set_req(i, 1'b1, we, a, d);
        @(posedge clk);
        @(negedge clk);
        chk("acc_gnt",   32'(gnt),       32'(1 << i));
        chk("acc_cs",    32'(ram_cs),    32'd1);
        chk("acc_write", 32'(ram_write), 32'(we));
        chk("acc_read",  32'(ram_read),  32'(!we));
        chk("acc_addr",  32'(ram_addr),  32'(a));
        if (we) chk("acc_wdata", 32'(ram_wdata), 32'(d));
        req[i] = 1'b0;
        @(negedge clk);
        chk("acc_resp_cs",   32'(ram_cs), 32'd0);
        chk("acc_resp_busy", 32'(busy),   32'd1);
        chk("acc_resp_gnt",  32'(gnt),    32'd0);
        @(negedge clk);
        chk("acc_done",  32'(done),  32'(1 << i));
        chk("acc_rdata", 32'(rdata), 32'(exp_rd));
        chk("acc_idle",  32'(busy),  32'd0);
    endtask

    function automatic int rr_model(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    typedef struct {
        int             idx;
        logic           we;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [DW-1:0]  exp_rd;
    } vec_t;

    vec_t vt [10];

    // Random-phase reference model state
    logic [7:0]    shadow [0:127] = '{default: 8'h00};
    bit            m_act;
    int            m_start, m_w, m_last, d, w;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd, exp_rd;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{0, 1'b1, 7'h05, 8'hA5, 8'h00};
        vt[1] = '{0, 1'b0, 7'h05, 8'h00, 8'hA5};
        vt[2] = '{1, 1'b1, 7'h7F, 8'hFF, 8'hA5};
        vt[3] = '{1, 1'b0, 7'h7F, 8'h00, 8'hFF};
        vt[4] = '{0, 1'b1, 7'h10, 8'h3C, 8'hFF};
        vt[5] = '{1, 1'b1, 7'h11, 8'hC3, 8'hFF};
        vt[6] = '{1, 1'b0, 7'h10, 8'h00, 8'h3C};
        vt[7] = '{0, 1'b0, 7'h11, 8'h00, 8'hC3};
        vt[8] = '{0, 1'b1, 7'h00, 8'h5A, 8'hC3};
        vt[9] = '{1, 1'b0, 7'h00, 8'h00, 8'h5A};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_gnt",   32'(gnt),       32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_rdata", 32'(rdata),     32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_cs",    32'(ram_cs),    32'd0);
        chk("rst_addr",  32'(ram_addr),  32'd0);
        chk("rst_wdata", 32'(ram_wdata), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("quiet_cs",    32'(ram_cs), 32'd0);
            chk("quiet_gnt",   32'(gnt),    32'd0);
            chk("quiet_done",  32'(done),   32'd0);
            chk("quiet_rdata", 32'(rdata),  32'd0);
        end

        // Table-driven single accesses
        for (int v = 0; v < 10; v++) begin
            do_access(vt[v].idx, vt[v].we, vt[v].addr, vt[v].wdata, vt[v].exp_rd);
        end

        // Both requesters reading continuously: grants alternate 0,1,0,1
        set_req(0, 1'b1, 1'b0, 7'h10, 8'h00);
        set_req(1, 1'b1, 1'b0, 7'h11, 8'h00);
        exp_rd = 8'h5A;
        for (int r = 1; r <= 12; r++) begin
            @(negedge clk);
            if (r % 3 == 1) begin
                chk("rr_gnt",  32'(gnt),      32'(1 << (((r - 1) / 3) % 2)));
                chk("rr_addr", 32'(ram_addr), (((r - 1) / 3) % 2 == 0) ? 32'h10 : 32'h11);
            end else begin
                chk("rr_gnt_low", 32'(gnt), 32'd0);
            end
            if (r % 3 == 0) begin
                exp_rd = (((r / 3) - 1) % 2 == 0) ? 8'h3C : 8'hC3;
                chk("rr_done", 32'(done), 32'(1 << (((r / 3) - 1) % 2)));
            end else begin
                chk("rr_done_low", 32'(done), 32'd0);
            end
            chk("rr_rdata", 32'(rdata), 32'(exp_rd));
        end
        req = '0;
        @(negedge clk);
        chk("rr_end_gnt",  32'(gnt),  32'd0);
        chk("rr_end_busy", 32'(busy), 32'd0);

        // Reset during CMD of a write
        set_req(0, 1'b1, 1'b1, 7'h20, 8'h77);
        @(posedge clk);
        @(negedge clk);
        chk("mid_cs",  32'(ram_cs),    32'd1);
        chk("mid_wr",  32'(ram_write), 32'd1);
        req = '0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_cs",   32'(ram_cs),    32'd0);
        chk("mid_rst_wr",   32'(ram_write), 32'd0);
        chk("mid_rst_busy", 32'(busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end
        chk("post_rst_rdata", 32'(rdata), 32'd0);
        set_req(0, 1'b1, 1'b0, 7'h05, 8'h00);
        set_req(1, 1'b1, 1'b0, 7'h7F, 8'h00);
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt), 32'd1);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_done0", 32'(done),  32'd1);
        chk("post_rst_rd",    32'(rdata), 32'hA5);

        // Randomized traffic against a transaction-level model
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        m_act  = 1'b0;
        m_last = N - 1;
        m_rd   = 8'h00;
        m_start = 0;
        m_w = 0;
        m_we = 1'b0;
        m_addr = '0;
        m_wd = '0;
        for (int n = 0; n < 900; n++) begin
            d = m_act ? (n - m_start) : -1;
            if (d == 3 && !m_we) m_rd = shadow[m_addr];
            chk("rnd_gnt",   32'(gnt),       (d == 1) ? 32'(1 << m_w) : 32'd0);
            chk("rnd_done",  32'(done),      (d == 3) ? 32'(1 << m_w) : 32'd0);
            chk("rnd_busy",  32'(busy),      (d == 1 || d == 2) ? 32'd1 : 32'd0);
            chk("rnd_cs",    32'(ram_cs),    (d == 1) ? 32'd1 : 32'd0);
            chk("rnd_write", 32'(ram_write), (d == 1 && m_we)  ? 32'd1 : 32'd0);
            chk("rnd_read",  32'(ram_read),  (d == 1 && !m_we) ? 32'd1 : 32'd0);
            if (d == 1) begin
                chk("rnd_addr", 32'(ram_addr), 32'(m_addr));
                if (m_we) chk("rnd_wdata", 32'(ram_wdata), 32'(m_wd));
            end
            chk("rnd_rdata", 32'(rdata), 32'(m_rd));
            if (d == 3) m_act = 1'b0;

            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (d == 1 && m_w == i) begin
                        if ($urandom % 2 == 0) req[i] = 1'b0;
                        else set_req(i, 1'b1, 1'($urandom % 2),
                                     7'h40 + 7'($urandom % 8), 8'($urandom));
                    end else if ($urandom % 16 == 0) begin
                        req[i] = 1'b0;
                    end
                end else if ($urandom % 3 == 0) begin
                    set_req(i, 1'b1, 1'($urandom % 2), 7'h40 + 7'($urandom % 8), 8'($urandom));
                end
            end

            if (!m_act && req != '0) begin
                w       = rr_model(req, m_last);
                m_act   = 1'b1;
                m_start = n;
                m_w     = w;
                m_last  = w;
                m_we    = req_we[w];
                m_addr  = req_addr[w*AW +: AW];
                m_wd    = req_wdata[w*DW +: DW];
                if (m_we) shadow[m_addr] = m_wd;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ram_rr_arbiter
`default_nettype wire

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Shares one 128x8 single-port RAM between NUM_REQ requesters, e.g. the TX framer and RX buffer paths.
- Each requester gets round-robin access.
- The block sequences one access at a time onto the RAM's CS/read/write/address/write_data pins.
- It captures the RAM's one-cycle-latency read_data and returns it to the granted requester with a done pulse.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 7, RAM address width (128 words).
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  per-requester access request, level.
- req_we  in  NUM_REQ  per-requester 1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  flattened write data.
- gnt  out  NUM_REQ  one-hot grant pulse, registered.
- done  out  NUM_REQ  one-hot completion pulse, registered.
- rdata  out  DATA_W  read result, valid while done is high; holds otherwise.
- busy  out  1  high in CMD or RESP.
- ram_cs  out  1  to RAM CS.
- ram_read  out  1  to RAM read.
- ram_write  out  1  to RAM write.
- ram_addr  out  ADDR_W  to RAM address.
- ram_wdata  out  DATA_W  to RAM write_data.
- ram_rdata  in  DATA_W  from RAM read_data.

Behaviour:
- Reset (async, immediate): state=IDLE; gnt=0, done=0, rdata=0, busy=0; ram_cs/ram_read/ram_write=0; ram_addr=0, ram_wdata=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- FSM states: IDLE, CMD, RESP.
- IDLE:
  - If any req is high on an edge, pick winner w by round robin: search starts at (last_grant+1) mod NUM_REQ, ascending, wrapping.
  - Latch req_we[w], req_addr[w], req_wdata[w]; set last_grant=w.
  - Pulse gnt[w] for the next cycle; go to CMD.
  - No req: stay in IDLE, outputs quiet.
- CMD (1 cycle):
  - ram_cs=1; ram_write=latched we; ram_read=!latched we; ram_addr/ram_wdata = latched values.
  - ram_read and ram_write are never high together. Always go to RESP.
- RESP (1 cycle):
  - ram_cs=ram_read=ram_write=0; ram_addr/ram_wdata hold.
  - For a read, ram_rdata is valid this cycle; on the exit edge, rdata<=ram_rdata.
  - For a write, rdata is unchanged.
  - On the exit edge, done[w]<=1 for one cycle; go to IDLE.
- RAM command outputs are decoded from the state register plus latched request registers. No combinational path from req to ram_*.
- Latency: req sampled at edge t; gnt high in cycle t+1 (CMD); done/rdata in cycle t+3. Peak throughput is one access per 3 cycles.
- Requester rules:
  - Hold req_we/addr/wdata stable until gnt is seen; only the grant edge is sampled.
  - For a single access, drop req on the edge after gnt; req still high in the done cycle is a new request.
- Simultaneous requests: exactly one gnt bit is ever high. A losing request stays pending and wins next if it is first after last_grant.
  - With both requesters continuously requesting, grants alternate 0,1,0,1.
- A req that drops before being granted is simply ignored; nothing is latched.
- Reset mid-operation: ram_cs drops asynchronously with rst. The in-flight access is abandoned with no done pulse. A write already clocked by the RAM remains in memory.
- The RAM's own rst is not driven by this block.

Decomposition:
- Package ram_arb_pkg: state encoding IDLE=2'd0, CMD=2'd1, RESP=2'd2; default ADDR_W/DATA_W constants.
- Sub-module rr_pick: purely combinational round-robin selector (inputs req vector and last_grant; outputs one-hot winner and its index plus any_req).
- The arbiter instantiates rr_pick once.

Test Plan:
- Reset release, req=0 for 10 cycles -> ram_cs never high, gnt/done=0, rdata=0x00.
- Req0 write addr 0x05 data 0xA5, then req0 read 0x05 -> ram_write=1 with ram_addr=0x05 in the CMD cycle. Read done[0] arrives 3 cycles after sampling, with rdata=0xA5.
- Req0 and req1 raised on the same edge, held 12 cycles, reading 0x10 and 0x11 (preloaded 0x3C/0xC3) -> gnt order 0,1,0,1. rdata alternates 0x3C/0xC3 with matching done bits.
- After a grant to 1, only req0 requests -> req0 granted next edge in IDLE. Wrap from index NUM_REQ-1 to 0 verified.
- Write to 0x7F with data 0xFF, then read 0x7F -> rdata=0xFF; address boundary has no wrap error.
- Assert rst during CMD of a write to 0x20 -> ram_cs drops in the same cycle, no done pulse, state IDLE. Next access is granted to requester 0.
